// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write-side arbiter.
// INSTR_REG_DEPTH must equal 2**$bits(address_t).
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    localparam int unsigned INSTR_REG_DEPTH = 32;

endpackage

// File: rtl/instr_register_rr_arb.sv
// Two-way round-robin arbiter.
// On a tie it grants the requester that was not accepted most recently.
module instr_register_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       grant_en,
    input  logic       accept,
    output logic [1:0] grant
);

    logic       last_grant;
    logic [1:0] pick;

    always_comb begin
        pick = valid;
        if (valid == 2'b11) begin
            pick = last_grant ? 2'b01 : 2'b10;
        end
        grant = grant_en ? pick : 2'b00;
    end

    // Resetting to 1 lets req0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/instr_register_arbiter.sv
// Write-side arbiter and read-side sequencer for the instruction register:
// round-robin accepts into a circular write pointer, FIFO pops via read pointer.
module instr_register_arbiter
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH = INSTR_REG_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  opcode_t                  req0_opcode,
    input  operand_t                 req0_operand_a,
    input  operand_t                 req0_operand_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  opcode_t                  req1_opcode,
    input  operand_t                 req1_operand_a,
    input  operand_t                 req1_operand_b,
    output logic                     load_en,
    output operand_t                 operand_a,
    output operand_t                 operand_b,
    output opcode_t                  opcode,
    output address_t                 write_pointer,
    output address_t                 read_pointer,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned         CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);

    address_t         head;
    address_t         tail;
    logic [CNT_W-1:0] occupied;
    logic             space;
    logic             push;
    logic             pop;
    logic [1:0]       grant;

    instr_register_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    ({req1_valid, req0_valid}),
        .grant_en (space),
        .accept   (push),
        .grant    (grant)
    );

    // The write still in flight on load_en already claims its slot.
    assign occupied   = count + CNT_W'(load_en);
    assign space      = occupied < DEPTH_C;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign rd_valid     = count != '0;
    assign pop          = rd_valid & rd_ready;
    assign read_pointer = head;
    assign empty        = count == '0;
    assign full         = count == DEPTH_C;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_en       <= 1'b0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            tail          <= '0;
            head          <= '0;
            count         <= '0;
        end else begin
            load_en <= push;
            if (push) begin
                opcode        <= grant[1] ? req1_opcode    : req0_opcode;
                operand_a     <= grant[1] ? req1_operand_a : req0_operand_a;
                operand_b     <= grant[1] ? req1_operand_b : req0_operand_b;
                write_pointer <= tail;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({load_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_register_arbiter.sv
// Self-checking bench for instr_register_arbiter: grant tables, write/read
// scoreboards and hand-written fill, wrap and commit-with-pop sequences.
module tb_instr_register_arbiter;
    import instr_register_pkg::*;

    localparam int unsigned CW = $clog2(INSTR_REG_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    opcode_t       req0_opcode, req1_opcode, opcode;
    operand_t      req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
    operand_t      operand_a, operand_b;
    logic          load_en, rd_valid, rd_ready, full, empty;
    address_t      write_pointer, read_pointer;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    instr_register_arbiter #(.DEPTH(INSTR_REG_DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_opcode    (req0_opcode),
        .req0_operand_a (req0_operand_a),
        .req0_operand_b (req0_operand_b),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_opcode    (req1_opcode),
        .req1_operand_a (req1_operand_a),
        .req1_operand_b (req1_operand_b),
        .load_en        (load_en),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .opcode         (opcode),
        .write_pointer  (write_pointer),
        .read_pointer   (read_pointer),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    typedef struct packed { opcode_t op; operand_t a; operand_t b; } instr_t;
    typedef struct packed { instr_t d; address_t wp; } wr_t;
    typedef struct { logic v0; logic v1; logic e0; logic e1; } vec_t;

    wr_t      wq[$];
    instr_t   rdq[$];
    instr_t   mem [INSTR_REG_DEPTH];
    wr_t      mon_w;
    address_t exp_wp = '0;
    address_t exp_rp = '0;
    int       checks = 0;
    int       errors = 0;
    vec_t     tbl [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Models the instruction register: capture every committed write.
    always @(negedge clk) begin
        if (reset_n && load_en) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_wp=%0d required=none", write_pointer);
            end else begin
                mon_w = wq.pop_front();
                chk("write", {opcode, operand_a, operand_b, write_pointer}, mon_w);
            end
            mem[write_pointer] = {opcode, operand_a, operand_b};
        end
    end

    task automatic set_req(input int n, input opcode_t op, input operand_t a, input operand_t b);
        if (n == 0) begin
            req0_opcode = op; req0_operand_a = a; req0_operand_b = b;
        end else begin
            req1_opcode = op; req1_operand_a = a; req1_operand_b = b;
        end
    endtask

    task automatic expect_accept(input instr_t d);
        wq.push_back({d, exp_wp});
        rdq.push_back(d);
        exp_wp++;
    endtask

    task automatic cycle(input logic v0, input logic v1, input logic rr,
                         input logic e0, input logic e1, input string nm);
        instr_t d;
        req0_valid = v0;
        req1_valid = v1;
        rd_ready   = rr;
        @(negedge clk);
        chk({nm, "_ready0"}, req0_ready, e0);
        chk({nm, "_ready1"}, req1_ready, e1);
        if (e0) expect_accept({req0_opcode, req0_operand_a, req0_operand_b});
        if (e1) expect_accept({req1_opcode, req1_operand_a, req1_operand_b});
        if (rr && rd_valid) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_spurious_pop actual_rp=%0d required=none", nm, read_pointer);
            end else begin
                d = rdq.pop_front();
                chk({nm, "_read_pointer"}, read_pointer, exp_rp);
                chk({nm, "_read_data"}, mem[read_pointer], d);
                exp_rp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 80 && (rdq.size() != 0 || wq.size() != 0); i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {nm, "_drain"});
        end
        chk({nm, "_unread"}, rdq.size(), 0);
        chk({nm, "_empty"}, empty, 1'b1);
        chk({nm, "_count0"}, count, 0);
    endtask

    task automatic do_reset(input string nm);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rd_ready   = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk({nm, "_rst_count"}, count, 0);
        chk({nm, "_rst_load_en"}, load_en, 1'b0);
        chk({nm, "_rst_wp"}, write_pointer, 0);
        chk({nm, "_rst_rp"}, read_pointer, 0);
        chk({nm, "_rst_rd_valid"}, rd_valid, 1'b0);
        chk({nm, "_rst_empty"}, empty, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        wq.delete();
        rdq.delete();
        exp_wp  = '0;
        exp_rp  = '0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        // Grant table; starts with last grant on req1.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0};

        req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
        set_req(0, ZERO, 0, 0);
        set_req(1, ZERO, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("init_load_en", load_en, 1'b0);
        chk("init_opcode", opcode, ZERO);
        chk("init_operands", {operand_a, operand_b}, 0);
        chk("init_pointers", {write_pointer, read_pointer}, 0);
        chk("init_count", count, 0);
        chk("init_flags", {empty, full, rd_valid}, 3'b100);
        chk("init_ready", {req1_ready, req0_ready}, 2'b00);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, latency to rd_valid, in-order pops.
        set_req(0, ADD, 5, 3);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "single0");
        chk("single_rdv_k1", rd_valid, 1'b0);
        set_req(0, SUB, 9, 4);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "single1");
        chk("single_rdv_k2", rd_valid, 1'b1);
        set_req(0, MULT, 2, 7);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "single2");
        drain("single");

        // Reset while a write is in flight.
        set_req(0, DIV, 11, 12);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "mid0");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "mid1");
        do_reset("mid");

        for (int i = 0; i < 6; i++) begin
            set_req(0, ADD, 100 + i, i);
            set_req(1, SUB, 200 + i, i);
            cycle(1'b1, 1'b1, 1'b0, (i % 2) == 0, (i % 2) == 1, $sformatf("alt%0d", i));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "alt_idle");
        chk("alt_count6", count, 6);

        for (int i = 0; i < 9; i++) begin
            set_req(0, opcode_t'(i % 8), 300 + i, 400 + i);
            set_req(1, opcode_t'((i + 3) % 8), 500 + i, 600 + i);
            cycle(tbl[i].v0, tbl[i].v1, 1'b0, tbl[i].e0, tbl[i].e1, $sformatf("tbl%0d", i));
        end
        drain("tbl");

        // Fill to DEPTH, hold against full, then one pop frees one slot.
        do_reset("fill");
        for (int i = 0; i < 32; i++) begin
            set_req(0, opcode_t'(i % 8), i, -i);
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("fill%0d", i));
        end
        set_req(0, PASSA, 77, 88);
        set_req(1, PASSB, 1, 2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_a");
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 32);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_b");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "full_pop");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "refill");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "refill_idle");
        chk("refill_count", count, 32);
        chk("refill_full", full, 1'b1);
        drain("fill");

        // Push and pop 40 one at a time: both pointers wrap 31 -> 0.
        do_reset("wrap");
        for (int i = 1; i <= 40; i++) begin
            set_req(0, opcode_t'(i % 8), 1000 + i, 2000 + i);
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("wrap%0d", i));
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wrap_commit");
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wrap_pop");
        end
        chk("wrap_wp", write_pointer, 7);
        chk("wrap_rp", read_pointer, 8);

        // Commit and pop on the same edge at count 1.
        set_req(0, ADD, 1, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "sim_a");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sim_b");
        chk("sim_count_start", count, 1);
        set_req(0, SUB, 2, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "sim_c");
        for (int i = 0; i < 4; i++) begin
            set_req(0, MULT, 3 + i, i);
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("sim%0d", i));
            chk($sformatf("sim%0d_count", i), count, 1);
            chk($sformatf("sim%0d_not_empty", i), empty, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sim_d");
        chk("sim_d_count", count, 1);
        chk("sim_d_not_empty", empty, 1'b0);
        drain("sim");

        chk("writes_outstanding", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
